// File: rtl/fiestel_pkg.sv
// Shared types and helpers for the iterative Feistel core.
// Holds the FSM state enum, mode codes and the byte S-box lookup.
package fiestel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entry S(16r+c) sits at bits [127-8c -: 8] of row r,
  // i.e. the low bit of that byte is 8*(15-c).
  function automatic logic [7:0] sbox_lookup(
    input logic [127:0] tbl [16],
    input logic [7:0]   b
  );
    logic [127:0] row;
    row = tbl[b[7:4]];
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fiestel_iterative_core_if.sv
// Block handshake bundle: input side (valid/ready/data/mode)
// and output side (valid/ready/data) of the Feistel core.
interface fiestel_iterative_core_if #(
  parameter int BLOCK_W = 256
);
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic [BLOCK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;

  modport master (
    output in_valid, mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fiestel_round_func.sv
// Combinational round function F(R,K) = rotl(S(R ^ K), ROT).
// Ports: sub_table (S-box rows), r_i, k_i in; f_o out.
module fiestel_round_func
  import fiestel_pkg::*;
#(
  parameter int HALF_W = 128,
  parameter int ROT    = 8
) (
  input  logic [127:0]      sub_table [16],
  input  logic [HALF_W-1:0] r_i,
  input  logic [HALF_W-1:0] k_i,
  output logic [HALF_W-1:0] f_o
);

  logic [HALF_W-1:0] x;
  logic [HALF_W-1:0] s;

  assign x = r_i ^ k_i;

  for (genvar i = 0; i < HALF_W / 8; i++) begin : g_sub
    assign s[8*i +: 8] = sbox_lookup(sub_table, x[8*i +: 8]);
  end

  // A shift by HALF_W yields zero, so ROT == 0 degenerates cleanly.
  assign f_o = (s << ROT) | (s >> (HALF_W - ROT));

endmodule

// File: rtl/fiestel_iterative_core.sv
// Iterative Feistel cipher core, one round per clock, enc/dec.
// Ports: clk, rst, sub_table, table/key valids, round_keys, busy, bus.
module fiestel_iterative_core
  import fiestel_pkg::*;
#(
  parameter int BLOCK_W    = 256,
  parameter int NUM_ROUNDS = 5,
  parameter int ROT        = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [127:0]                        sub_table [16],
  input  logic                                substitution_table_valid,
  input  logic [NUM_ROUNDS*(BLOCK_W/2)-1:0]   round_keys,
  input  logic                                keys_valid,
  output logic                                busy,
  fiestel_iterative_core_if.slave             bus
);

  localparam int HALF_W = BLOCK_W / 2;
  localparam int CNT_W  = cnt_width(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

  state_e             state_q;
  logic [HALF_W-1:0]  l_q, r_q;
  logic [HALF_W-1:0]  l_d, r_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q;
  logic               out_valid_q;
  logic [BLOCK_W-1:0] out_data_q;

  logic [CNT_W-1:0]   idx;
  logic [HALF_W-1:0]  key;
  logic [HALF_W-1:0]  f;
  logic               accept;

  // Decrypt walks the key schedule backwards.
  assign idx = (mode_q == MODE_DEC) ? (LAST - cnt_q) : cnt_q;
  assign key = round_keys[idx*HALF_W +: HALF_W];

  fiestel_round_func #(
    .HALF_W (HALF_W),
    .ROT    (ROT)
  ) u_f (
    .sub_table (sub_table),
    .r_i       (r_q),
    .k_i       (key),
    .f_o       (f)
  );

  assign l_d = r_q;
  assign r_d = l_q ^ f;

  assign bus.in_ready = ~rst
                      & substitution_table_valid
                      & keys_valid
                      & ((state_q == IDLE)
                      |  ((state_q == DONE) & bus.out_ready));

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_ENC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            l_q     <= bus.in_data[BLOCK_W-1:HALF_W];
            r_q     <= bus.in_data[HALF_W-1:0];
            mode_q  <= bus.mode;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          l_q <= l_d;
          r_q <= r_d;
          if (cnt_q == LAST) begin
            // Final swap: emit {R, L} so decrypt reuses this path.
            out_data_q  <= {r_d, l_d};
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              l_q     <= bus.in_data[BLOCK_W-1:HALF_W];
              r_q     <= bus.in_data[HALF_W-1:0];
              mode_q  <= bus.mode;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fiestel_iterative_core.sv
// Directed bench for fiestel_iterative_core (default and 1-round).
// Ref model recomputes rounds from a flat 256-entry S-box copy.
module tb_fiestel_iterative_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] tbl [16];
  logic [7:0]   sb  [256];
  logic         tv;
  logic         kv;
  logic [639:0] ks;
  logic [127:0] ks1;
  logic         busy0, busy1;

  int checks = 0;
  int errors = 0;

  fiestel_iterative_core_if #(.BLOCK_W(256)) b0 ();
  fiestel_iterative_core_if #(.BLOCK_W(256)) b1 ();

  fiestel_iterative_core u0 (
    .clk                      (clk),
    .rst                      (rst),
    .sub_table                (tbl),
    .substitution_table_valid (tv),
    .round_keys               (ks),
    .keys_valid               (kv),
    .busy                     (busy0),
    .bus                      (b0)
  );

  fiestel_iterative_core #(.NUM_ROUNDS(1)) u1 (
    .clk                      (clk),
    .rst                      (rst),
    .sub_table                (tbl),
    .substitution_table_valid (tv),
    .round_keys               (ks1),
    .keys_valid               (kv),
    .busy                     (busy1),
    .bus                      (b1)
  );

  localparam logic [255:0] P =
    256'h8b0fc5ee_3c9a1d47_56e2b830_09f4a1c6_7d2e5b91_c0a3f817_4e6b29d5_b58e07a0;
  localparam logic [639:0] KS = {
    128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3,
    128'h13579bdf_2468ace0_0badf00d_cafebabe,
    128'hdeadbeef_01234567_89abcdef_fedcba98,
    128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
    128'h8754aa13_0012e231_88567534_b3a27524
  };

  function automatic logic [255:0] ref_model(
    input logic [255:0] d, input logic [639:0] k, input bit dec
  );
    logic [127:0] l, r, x, s, f, t, kk;
    l = d[255:128];
    r = d[127:0];
    for (int i = 0; i < 5; i++) begin
      kk = k[(dec ? 4 - i : i)*128 +: 128];
      x = r ^ kk;
      for (int b = 0; b < 16; b++) s[8*b +: 8] = sb[x[8*b +: 8]];
      for (int j = 0; j < 128; j++) f[(j + 8) % 128] = s[j];
      t = r;
      r = l ^ f;
      l = t;
    end
    return {r, l};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send(input logic [255:0] d, input logic m);
    int n;
    n = 0;
    b0.in_data  = d;
    b0.mode     = m;
    b0.in_valid = 1'b1;
    #1;
    while (!b0.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 256'(n), 256'(0));
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!b0.out_valid && lat < 50);
  endtask

  logic [255:0] cap, ct;
  logic [255:0] blk [4];
  int lat, na, no, last, seen;

  initial begin
    tbl[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    tbl[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    tbl[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    tbl[3]  = 128'h04c723c31896059a071280e2eb27b275;
    tbl[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    tbl[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    tbl[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    tbl[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    tbl[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    tbl[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    tbl[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    tbl[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    tbl[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    tbl[13] = 128'h703eb5664803f60e613557b986c11d9e;
    tbl[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    tbl[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sb[16*r + c] = tbl[r][127 - 8*c -: 8];

    tv = 1'b1;
    kv = 1'b1;
    ks = '0;
    ks1 = '0;
    b0.in_valid = 0; b0.mode = 0; b0.in_data = '0; b0.out_ready = 1;
    b1.in_valid = 0; b1.mode = 0; b1.in_data = '0; b1.out_ready = 1;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 256'(b0.out_valid), 256'(0));
    chk("rst_out_data", b0.out_data, 256'h0);
    chk("rst_busy", 256'(busy0), 256'(0));
    chk("rst_in_ready", 256'(b0.in_ready), 256'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 256'(b0.in_ready), 256'(1));

    // One-round core, zero key and data
    b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    chk("r1_not_yet", 256'(b1.out_valid), 256'(0));
    @(posedge clk); #1;
    chk("r1_valid", 256'(b1.out_valid), 256'(1));
    chk("r1_data", b1.out_data, {{16{8'h63}}, 128'h0});
    @(posedge clk); #1;
    chk("r1_drop", 256'(b1.out_valid), 256'(0));
    chk("r1_idle", 256'(busy1), 256'(0));

    // Five rounds, zero key and data: hand-traced byte chain
    send(256'h0, 1'b0);
    wait_out(lat);
    chk("zero_latency", 256'(lat), 256'(5));
    chk("zero_data", b0.out_data, {{16{8'h0e}}, {16{8'hab}}});

    // Encrypt then decrypt with a full key schedule
    ks = KS;
    @(posedge clk); #1;
    send(P, 1'b0);
    wait_out(lat);
    ct = b0.out_data;
    chk("enc_data", ct, ref_model(P, KS, 1'b0));
    checks++;
    assert (ct !== P) else begin
      errors++;
      $display("FAIL enc_differs observed=%h expected!=%h", ct, P);
      $error("check enc_differs");
    end
    @(posedge clk); #1;
    send(ct, 1'b1);
    wait_out(lat);
    chk("dec_data", b0.out_data, P);

    // Back-pressure in DONE
    @(posedge clk); #1;
    b0.out_ready = 1'b0;
    send(~P, 1'b0);
    wait_out(lat);
    cap = b0.out_data;
    chk("bp_data", cap, ref_model(~P, KS, 1'b0));
    b0.in_data  = P ^ 256'h1;
    b0.mode     = 1'b0;
    b0.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 256'(b0.out_valid), 256'(1));
      chk("bp_hold_data", b0.out_data, cap);
      chk("bp_in_ready", 256'(b0.in_ready), 256'(0));
      @(posedge clk); #1;
    end
    b0.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 256'(b0.in_ready), 256'(1));
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    chk("bp_reaccept_busy", 256'(busy0), 256'(1));
    chk("bp_reaccept_valid", 256'(b0.out_valid), 256'(0));
    wait_out(lat);
    chk("bp_next_data", b0.out_data, ref_model(P ^ 256'h1, KS, 1'b0));
    @(posedge clk); #1;
    chk("bp_to_idle", 256'(busy0), 256'(0));

    // Back-to-back streaming, four blocks
    blk[0] = P;
    blk[1] = ~P;
    blk[2] = {P[127:0], P[255:128]};
    blk[3] = 256'h1;
    na = 0; no = 0; last = 0;
    b0.in_data  = blk[0];
    b0.mode     = 1'b0;
    b0.in_valid = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && no < 4; cyc++) begin
      bit acc;
      acc = b0.in_valid && b0.in_ready;
      if (b0.out_valid) begin
        chk("stream_out", b0.out_data, ref_model(blk[no], KS, 1'b0));
        no++;
      end
      if (acc) begin
        if (na > 0) chk("stream_gap", 256'(cyc - last), 256'(6));
        last = cyc;
        na++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (na < 4) b0.in_data = blk[na];
        else b0.in_valid = 1'b0;
      end
    end
    chk("stream_count", 256'(no), 256'(4));
    b0.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN
    send(P, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 256'(busy0), 256'(0));
    chk("midrst_valid", 256'(b0.out_valid), 256'(0));
    chk("midrst_data", b0.out_data, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b0.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_out", 256'(seen), 256'(0));
    send(P, 1'b0);
    wait_out(lat);
    chk("postrst_data", b0.out_data, ct);

    // Table not valid blocks accept
    @(posedge clk); #1;
    tv = 1'b0;
    b0.in_data  = ct;
    b0.mode     = 1'b1;
    b0.in_valid = 1'b1;
    #1;
    chk("tv0_in_ready", 256'(b0.in_ready), 256'(0));
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("tv0_no_accept", 256'(busy0), 256'(0));
    tv = 1'b1;
    #1;
    chk("tv1_in_ready", 256'(b0.in_ready), 256'(1));
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    chk("tv1_accept", 256'(busy0), 256'(1));
    wait_out(lat);
    chk("tv1_latency", 256'(lat), 256'(5));
    chk("tv1_dec_data", b0.out_data, P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
